bot_update_ctrl: RTL and testbench

Sequences the update handshake between the rojobot register block and the MIPSfpga I/O interface, in place of the bare set/clear flip-flop.
- Detects each rising edge of upd_sysregs and snapshots the 32-bit bot info word.
- Raises update_pending and holds it until the CPU acks.
- Counts updates the CPU missed, detects a CPU that never acks, and registers the motor-control byte going back to the bot.

---
 rtl/bot_update_ctrl.sv | 117 +++++++++++
 tb/tb_bot_update_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bot_update_ctrl.sv
// Rojobot <-> MIPSfpga update handshake: edge-detected snapshot, pending flag, overrun/timeout status.
// Optional: define BOT_UPDATE_CTRL_STOP_ON_TIMEOUT_EN to force motctl_out to 0 while timeout is set.
module bot_update_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned OVR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_sysregs,
  input  logic [31:0]       bot_info_in,
  input  logic              int_ack,
  input  logic              clr_status,
  input  logic [7:0]        motctl_in,
  output logic [31:0]       bot_info_out,
  output logic              update_pending,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic              timeout,
  output logic [7:0]        motctl_out
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t            state_q, state_d;
  logic              upd_q;
  logic [31:0]       info_q, info_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              to_q, to_d;
  logic [7:0]        mot_q, mot_d;
  logic              upd_edge;
  logic              ovr_inc;
  logic              to_set;

  assign upd_edge = upd_sysregs & ~upd_q;

  always_comb begin
    state_d = state_q;
    info_d  = info_q;
    timer_d = timer_q;
    ovr_inc = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd_edge) begin
          info_d  = bot_info_in;
          timer_d = '0;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // Ack with a fresh edge consumes the old snapshot, so it is not an overrun.
        if (int_ack && upd_edge) begin
          info_d  = bot_info_in;
          timer_d = '0;
        end else if (int_ack) begin
          state_d = IDLE;
        end else if (upd_edge) begin
          info_d  = bot_info_in;
          timer_d = '0;
          ovr_inc = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          to_set  = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ovr_d = ovr_q;
    if (ovr_inc && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
    if (clr_status) ovr_d = '0;

    // A timeout raised in the same cycle as a clear must survive it.
    to_d = to_q;
    if (clr_status) to_d = 1'b0;
    if (to_set)     to_d = 1'b1;

`ifdef BOT_UPDATE_CTRL_STOP_ON_TIMEOUT_EN
    mot_d = to_q ? 8'h00 : motctl_in;
`else
    mot_d = motctl_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      upd_q   <= 1'b0;
      info_q  <= '0;
      timer_q <= '0;
      ovr_q   <= '0;
      to_q    <= 1'b0;
      mot_q   <= '0;
    end else begin
      state_q <= state_d;
      upd_q   <= upd_sysregs;
      info_q  <= info_d;
      timer_q <= timer_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
      mot_q   <= mot_d;
    end
  end

  assign bot_info_out   = info_q;
  assign update_pending = (state_q == PENDING);
  assign overrun_cnt    = ovr_q;
  assign timeout        = to_q;
  assign motctl_out     = mot_q;

endmodule

// File: tb/tb_bot_update_ctrl.sv
// Self-checking bench for bot_update_ctrl: vector table plus hand sequences, checked through a scoreboard queue.
module tb_bot_update_ctrl;

`ifdef BOT_UPDATE_CTRL_STOP_ON_TIMEOUT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct {
    logic        rst, upd, ack, clr;
    logic [31:0] data;
    logic [7:0]  mot;
    logic        e_pend;
    logic [31:0] e_info;
    logic [7:0]  e_ovr;
    logic        e_to;
    logic [7:0]  e_mot;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, upd_sysregs, int_ack, clr_status;
  logic [31:0] bot_info_in;
  logic [7:0]  motctl_in;
  logic [31:0] bot_info_out, bot_info_out_s;
  logic        update_pending, update_pending_s;
  logic [7:0]  overrun_cnt;
  logic [1:0]  overrun_cnt_s;
  logic        timeout, timeout_s;
  logic [7:0]  motctl_out, motctl_out_s;

  int errors = 0;
  int checks = 0;
  int vidx   = 0;
  vec_t exp_q[$];
  vec_t tbl[26];

  always #5 clk = ~clk;

  bot_update_ctrl #(.TIMEOUT_CYCLES(16), .OVR_W(8)) dut (
    .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs), .bot_info_in(bot_info_in),
    .int_ack(int_ack), .clr_status(clr_status), .motctl_in(motctl_in),
    .bot_info_out(bot_info_out), .update_pending(update_pending),
    .overrun_cnt(overrun_cnt), .timeout(timeout), .motctl_out(motctl_out)
  );

  bot_update_ctrl #(.TIMEOUT_CYCLES(16), .OVR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs), .bot_info_in(bot_info_in),
    .int_ack(int_ack), .clr_status(clr_status), .motctl_in(motctl_in),
    .bot_info_out(bot_info_out_s), .update_pending(update_pending_s),
    .overrun_cnt(overrun_cnt_s), .timeout(timeout_s), .motctl_out(motctl_out_s)
  );

  function automatic vec_t mk(logic rst, logic upd, logic ack, logic clr, logic [31:0] data,
                              logic [7:0] mot, logic e_pend, logic [31:0] e_info,
                              logic [7:0] e_ovr, logic e_to);
    vec_t v;
    v.rst = rst; v.upd = upd; v.ack = ack; v.clr = clr; v.data = data; v.mot = mot;
    v.e_pend = e_pend; v.e_info = e_info; v.e_ovr = e_ovr; v.e_to = e_to;
    v.e_mot = rst ? 8'h00 : mot;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, vidx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    logic [1:0] sat_exp;
    reset       = v.rst;
    upd_sysregs = v.upd;
    int_ack     = v.ack;
    clr_status  = v.clr;
    bot_info_in = v.data;
    motctl_in   = v.mot;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    sat_exp = (e.e_ovr > 8'd3) ? 2'd3 : e.e_ovr[1:0];
    chk("update_pending", {31'd0, update_pending}, {31'd0, e.e_pend});
    chk("bot_info_out",   bot_info_out,            e.e_info);
    chk("overrun_cnt",    {24'd0, overrun_cnt},    {24'd0, e.e_ovr});
    chk("timeout",        {31'd0, timeout},        {31'd0, e.e_to});
    chk("motctl_out",     {24'd0, motctl_out},     {24'd0, e.e_mot});
    chk("overrun_sat",    {30'd0, overrun_cnt_s},  {30'd0, sat_exp});
    vidx++;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; upd_sysregs = 1'b0; int_ack = 1'b0; clr_status = 1'b0;
    bot_info_in = '0; motctl_in = '0;

    //           rst upd ack clr data           mot    pend info           ovr  to
    tbl[0]  = mk(1, 0, 0, 0, JUNK,          8'h00, 0, 32'h0,          8'd0, 0);
    tbl[1]  = mk(0, 0, 1, 0, JUNK,          8'h01, 0, 32'h0,          8'd0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h1234_5678, 8'h02, 1, 32'h1234_5678,  8'd0, 0);
    tbl[3]  = mk(0, 0, 0, 0, JUNK,          8'h03, 1, 32'h1234_5678,  8'd0, 0);
    tbl[4]  = mk(0, 0, 0, 0, JUNK,          8'h04, 1, 32'h1234_5678,  8'd0, 0);
    tbl[5]  = mk(0, 0, 1, 0, JUNK,          8'h05, 0, 32'h1234_5678,  8'd0, 0);
    tbl[6]  = mk(0, 0, 1, 0, JUNK,          8'h06, 0, 32'h1234_5678,  8'd0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 32'hAAAA_0001, 8'h07, 1, 32'hAAAA_0001,  8'd0, 0);
    tbl[8]  = mk(0, 0, 0, 0, JUNK,          8'h08, 1, 32'hAAAA_0001,  8'd0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 32'hBBBB_0002, 8'h09, 1, 32'hBBBB_0002,  8'd1, 0);
    tbl[10] = mk(0, 0, 0, 0, JUNK,          8'h0A, 1, 32'hBBBB_0002,  8'd1, 0);
    tbl[11] = mk(0, 1, 0, 0, 32'hCCCC_0003, 8'h0B, 1, 32'hCCCC_0003,  8'd2, 0);
    tbl[12] = mk(0, 0, 0, 0, JUNK,          8'h0C, 1, 32'hCCCC_0003,  8'd2, 0);
    tbl[13] = mk(0, 0, 1, 0, JUNK,          8'h0D, 0, 32'hCCCC_0003,  8'd2, 0);
    tbl[14] = mk(0, 1, 0, 0, 32'h1111_0000, 8'h0E, 1, 32'h1111_0000,  8'd2, 0);
    tbl[15] = mk(0, 0, 0, 0, JUNK,          8'h0F, 1, 32'h1111_0000,  8'd2, 0);
    tbl[16] = mk(0, 1, 1, 0, 32'hDDDD_0004, 8'h10, 1, 32'hDDDD_0004,  8'd2, 0);
    tbl[17] = mk(0, 0, 1, 0, JUNK,          8'h11, 0, 32'hDDDD_0004,  8'd2, 0);
    tbl[18] = mk(0, 0, 0, 1, JUNK,          8'h12, 0, 32'hDDDD_0004,  8'd0, 0);
    tbl[19] = mk(0, 1, 0, 0, 32'hEEEE_0005, 8'h13, 1, 32'hEEEE_0005,  8'd0, 0);
    tbl[20] = mk(0, 0, 0, 0, JUNK,          8'h14, 1, 32'hEEEE_0005,  8'd0, 0);
    tbl[21] = mk(0, 1, 0, 1, 32'hFFFF_0006, 8'h15, 1, 32'hFFFF_0006,  8'd0, 0);
    tbl[22] = mk(0, 0, 0, 0, JUNK,          8'h16, 1, 32'hFFFF_0006,  8'd0, 0);
    tbl[23] = mk(0, 1, 0, 0, 32'hCCCC_0003, 8'h17, 1, 32'hCCCC_0003,  8'd1, 0);
    tbl[24] = mk(0, 0, 1, 1, JUNK,          8'h18, 0, 32'hCCCC_0003,  8'd0, 0);
    tbl[25] = mk(0, 0, 0, 0, JUNK,          8'h19, 0, 32'hCCCC_0003,  8'd0, 0);

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout: 16th edge after entering PENDING declares it.
    apply(mk(0, 1, 0, 0, 32'h5555_5555, 8'h33, 1, 32'h5555_5555, 8'd0, 0));
    for (int k = 1; k <= 15; k++)
      apply(mk(0, 0, 0, 0, JUNK, 8'h33, 1, 32'h5555_5555, 8'd0, 0));
    apply(mk(0, 0, 0, 0, JUNK, 8'h33, 0, 32'h5555_5555, 8'd0, 1));
    for (int k = 0; k < 2; k++) begin
      v = mk(0, 0, 0, 0, JUNK, 8'h33, 0, 32'h5555_5555, 8'd0, 1);
      v.e_mot = STOP_EN ? 8'h00 : 8'h33;
      apply(v);
    end
    v = mk(0, 0, 0, 1, JUNK, 8'h33, 0, 32'h5555_5555, 8'd0, 0);
    v.e_mot = STOP_EN ? 8'h00 : 8'h33;
    apply(v);
    apply(mk(0, 0, 0, 0, JUNK, 8'h33, 0, 32'h5555_5555, 8'd0, 0));

    // Timeout coinciding with clr_status: timeout wins.
    apply(mk(0, 1, 0, 0, 32'h6666_6666, 8'h33, 1, 32'h6666_6666, 8'd0, 0));
    for (int k = 1; k <= 15; k++)
      apply(mk(0, 0, 0, 0, JUNK, 8'h33, 1, 32'h6666_6666, 8'd0, 0));
    apply(mk(0, 0, 0, 1, JUNK, 8'h33, 0, 32'h6666_6666, 8'd0, 1));
    v = mk(0, 0, 0, 1, JUNK, 8'h33, 0, 32'h6666_6666, 8'd0, 0);
    v.e_mot = STOP_EN ? 8'h00 : 8'h33;
    apply(v);
    apply(mk(0, 0, 0, 0, JUNK, 8'h33, 0, 32'h6666_6666, 8'd0, 0));

    // Held strobe: one capture only, even across the timeout.
    for (int k = 0; k < 50; k++)
      apply(mk(0, 1, 0, 0, 32'h7000_0000 + 32'(k), 8'h00, (k <= 15), 32'h7000_0000,
               8'd0, (k >= 16)));
    apply(mk(0, 0, 0, 1, JUNK, 8'h00, 0, 32'h7000_0000, 8'd0, 0));

    // Overrun to 4 (saturating instance stops at 3), then reset mid-PENDING.
    apply(mk(1, 0, 0, 0, JUNK, 8'h21, 0, 32'h0, 8'd0, 0));
    for (int e = 0; e < 5; e++) begin
      apply(mk(0, 1, 0, 0, 32'h8000_0000 + 32'(e), 8'h22, 1, 32'h8000_0000 + 32'(e),
               8'(e), 0));
      apply(mk(0, 0, 0, 0, JUNK, 8'h23, 1, 32'h8000_0000 + 32'(e), 8'(e), 0));
    end
    apply(mk(1, 0, 0, 0, JUNK, 8'h24, 0, 32'h0, 8'd0, 0));
    apply(mk(0, 0, 1, 0, JUNK, 8'h44, 0, 32'h0, 8'd0, 0));
    apply(mk(0, 0, 0, 0, JUNK, 8'h45, 0, 32'h0, 8'd0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
